// File: rtl/audio_mem_fetch.sv
// Memory-side server for the audio mixer's sample fetch port: steers each request to
// VRAM or TILE memory, waits for grant plus read latency, and returns the word with an ack.
module audio_mem_fetch #(
   parameter int unsigned VRAM_W     = 16,
   parameter int unsigned TILE_W     = 12,
   parameter int unsigned TILE_WORDS = 5120,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset_n_i,
   input  logic              audio_req_i,
   input  logic              audio_tile_i,
   input  logic [VRAM_W-1:0] audio_addr_i,
   output logic              audio_ack_o,
   output logic [15:0]       audio_word_o,
   output logic              vram_sel_o,
   output logic [VRAM_W-1:0] vram_addr_o,
   input  logic              vram_grant_i,
   input  logic [15:0]       vram_data_i,
   output logic              tile_sel_o,
   output logic [TILE_W-1:0] tile_addr_o,
   input  logic              tile_grant_i,
   input  logic [15:0]       tile_data_i,
   output logic              err_o,
   input  logic              err_clr_i
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_ACK   = 3'd3,
      S_COOL  = 3'd4
   } state_e;

   localparam logic [VRAM_W:0] TILE_LIM = (VRAM_W+1)'(TILE_WORDS);
   localparam logic [1:0]      LAT_LOAD = 2'(MEM_LAT);
   localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

   state_e              state_q;
   logic                tile_q;
   logic                drop_q;
   logic [1:0]          lat_q;
   logic [7:0]          to_q;
   logic                ack_q;
   logic [15:0]         word_q;
   logic                vsel_q;
   logic                tsel_q;
   logic [VRAM_W-1:0]   vaddr_q;
   logic [TILE_W-1:0]   taddr_q;
   logic                err_q;

   logic                grant;
   logic [15:0]         rdata;
   logic                oor;

   // Grant and data of the latched memory only; range check on the live request.
   always_comb begin
      grant = 1'b0;
      rdata = 16'h0000;
      if (tile_q) begin
         grant = tile_grant_i;
         rdata = tile_data_i;
      end else begin
         grant = vram_grant_i;
         rdata = vram_data_i;
      end
      oor = audio_tile_i && ({1'b0, audio_addr_i} >= TILE_LIM);
   end

   // Fetch FSM with registered outputs; a later err_q set overrides the clear.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         tile_q  <= 1'b0;
         drop_q  <= 1'b0;
         lat_q   <= 2'd0;
         to_q    <= 8'd0;
         ack_q   <= 1'b0;
         word_q  <= 16'h0000;
         vsel_q  <= 1'b0;
         tsel_q  <= 1'b0;
         vaddr_q <= '0;
         taddr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (err_clr_i) begin
            err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (audio_req_i) begin
                  tile_q <= audio_tile_i;
                  to_q   <= 8'd0;
                  drop_q <= 1'b0;
                  if (oor) begin
                     word_q  <= 16'h0000;
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= S_ACK;
                  end else begin
                     vsel_q  <= ~audio_tile_i;
                     tsel_q  <= audio_tile_i;
                     vaddr_q <= audio_addr_i;
                     taddr_q <= audio_addr_i[TILE_W-1:0];
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // A grant commits the read even if the mixer drops its request now.
               if (grant) begin
                  vsel_q  <= 1'b0;
                  tsel_q  <= 1'b0;
                  lat_q   <= LAT_LOAD;
                  drop_q  <= ~audio_req_i;
                  state_q <= S_WAIT;
               end else if (!audio_req_i) begin
                  vsel_q  <= 1'b0;
                  tsel_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (to_q == TO_LAST) begin
                  vsel_q  <= 1'b0;
                  tsel_q  <= 1'b0;
                  word_q  <= 16'h0000;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_ACK;
               end else begin
                  to_q <= to_q + 8'd1;
               end
            end
            S_WAIT: begin
               if (lat_q == 2'd1) begin
                  word_q <= rdata;
                  if (drop_q || !audio_req_i) begin
                     state_q <= S_COOL;
                  end else begin
                     ack_q   <= 1'b1;
                     state_q <= S_ACK;
                  end
               end else begin
                  lat_q  <= lat_q - 2'd1;
                  drop_q <= drop_q | ~audio_req_i;
               end
            end
            S_ACK: begin
               state_q <= S_COOL;
            end
            S_COOL: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign audio_ack_o  = ack_q;
   assign audio_word_o = word_q;
   assign vram_sel_o   = vsel_q;
   assign vram_addr_o  = vaddr_q;
   assign tile_sel_o   = tsel_q;
   assign tile_addr_o  = taddr_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_audio_mem_fetch.sv
// Randomized bench for audio_mem_fetch: each fetch is described by its grant delay,
// withdrawal point and error-clear pulse; expected outputs follow from the timing rules.
module tb_audio_mem_fetch;

   localparam int VW     = 16;
   localparam int TW     = 12;
   localparam int TWORDS = 5120;
   localparam int LAT    = 2;
   localparam int TO     = 8;

   logic          clk;
   logic          reset_n_i;
   logic          audio_req_i;
   logic          audio_tile_i;
   logic [VW-1:0] audio_addr_i;
   logic          audio_ack_o;
   logic [15:0]   audio_word_o;
   logic          vram_sel_o;
   logic [VW-1:0] vram_addr_o;
   logic          vram_grant_i;
   logic [15:0]   vram_data_i;
   logic          tile_sel_o;
   logic [TW-1:0] tile_addr_o;
   logic          tile_grant_i;
   logic [15:0]   tile_data_i;
   logic          err_o;
   logic          err_clr_i;

   audio_mem_fetch #(
      .VRAM_W(VW), .TILE_W(TW), .TILE_WORDS(TWORDS), .MEM_LAT(LAT), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n_i(reset_n_i),
      .audio_req_i(audio_req_i), .audio_tile_i(audio_tile_i), .audio_addr_i(audio_addr_i),
      .audio_ack_o(audio_ack_o), .audio_word_o(audio_word_o),
      .vram_sel_o(vram_sel_o), .vram_addr_o(vram_addr_o),
      .vram_grant_i(vram_grant_i), .vram_data_i(vram_data_i),
      .tile_sel_o(tile_sel_o), .tile_addr_o(tile_addr_o),
      .tile_grant_i(tile_grant_i), .tile_data_i(tile_data_i),
      .err_o(err_o), .err_clr_i(err_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_ack = 0;
   bit          last_ok = 1'b0;
   logic [15:0] word_m = 16'h0000;
   logic        err_m = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ack"},   32'(audio_ack_o),  32'd0);
      check_val({tag, "_word"},  32'(audio_word_o), 32'd0);
      check_val({tag, "_vsel"},  32'(vram_sel_o),   32'd0);
      check_val({tag, "_tsel"},  32'(tile_sel_o),   32'd0);
      check_val({tag, "_vaddr"}, 32'(vram_addr_o),  32'd0);
      check_val({tag, "_taddr"}, 32'(tile_addr_o),  32'd0);
      check_val({tag, "_err"},   32'(err_o),        32'd0);
   endtask

   // One mixer fetch starting in the current cycle (k=0). g: grant delay in cycles
   // (>= TO means never granted); wd: cycle at which req is dropped (0 = held until
   // ack); clr_k: cycle carrying an err_clr_i pulse (-1 = none).
   task automatic fetch(input logic t, input logic [15:0] a, input int g, input int wd_in,
                        input int clr_k);
      logic [15:0] dv [64];
      logic [15:0] dt [64];
      bit oor;
      bit supp;
      int wd, sel_last, done_k, ack_k, set_k, grant_k, end_k;
      logic exp_vs, exp_ts;
      oor      = t && (a >= 16'(TWORDS));
      wd       = oor ? 0 : wd_in;
      supp     = 1'b0;
      sel_last = 0;
      done_k   = -1;
      ack_k    = -1;
      set_k    = -1;
      grant_k  = -1;
      if (oor) begin
         done_k = 1; ack_k = 1; set_k = 1; end_k = 3;
      end else if (wd > 0 && wd <= g) begin
         sel_last = wd; end_k = wd + 3;
      end else if (g >= TO) begin
         sel_last = TO; done_k = TO + 1; ack_k = done_k; set_k = done_k; end_k = done_k + 2;
      end else begin
         sel_last = g + 1; grant_k = g + 1; done_k = g + 2 + LAT;
         supp = (wd > 0);
         if (!supp) ack_k = done_k;
         end_k = done_k + 2;
      end
      for (int k = 0; k <= end_k; k++) begin
         if (k > 0) begin
            tick();
            if (k == done_k)
               word_m = (grant_k >= 0) ? (t ? dt[grant_k+LAT] : dv[grant_k+LAT]) : 16'h0000;
            if (k == set_k) err_m = 1'b1;
            else if (clr_k >= 0 && k == clr_k + 1) err_m = 1'b0;
            exp_vs = !t && (k <= sel_last);
            exp_ts = t && (k <= sel_last);
            check_val("vram_sel", 32'(vram_sel_o), 32'(exp_vs));
            check_val("tile_sel", 32'(tile_sel_o), 32'(exp_ts));
            if (exp_vs) check_val("vram_addr", 32'(vram_addr_o), 32'(a));
            if (exp_ts) check_val("tile_addr", 32'(tile_addr_o), 32'(a[TW-1:0]));
            check_val("ack", 32'(audio_ack_o), 32'(k == ack_k));
            check_val("word", 32'(audio_word_o), 32'(word_m));
            check_val("err", 32'(err_o), 32'(err_m));
            if (k == ack_k && grant_k >= 0) begin
               if (last_ok) check_val("spacing", 32'((cyc - last_ack) >= 4 + LAT), 32'd1);
               last_ack = cyc;
               last_ok  = 1'b1;
            end
         end
         audio_req_i = (wd > 0) ? (k < wd) : (k < ack_k + 2);
         if (k == 0) begin
            audio_tile_i = t;
            audio_addr_i = a;
         end else begin
            audio_tile_i = 1'($urandom);
            audio_addr_i = 16'($urandom);
         end
         vram_data_i  = 16'($urandom);
         tile_data_i  = 16'($urandom);
         dv[k]        = vram_data_i;
         dt[k]        = tile_data_i;
         vram_grant_i = t ? 1'($urandom) : (k == grant_k);
         tile_grant_i = t ? (k == grant_k) : 1'($urandom);
         err_clr_i    = (k == clr_k);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g, wd, clr, m;
      logic t;
      logic [15:0] a;
      reset_n_i = 1'b0; audio_req_i = 1'b0; audio_tile_i = 1'b0; audio_addr_i = 16'h0000;
      vram_grant_i = 1'b0; tile_grant_i = 1'b0; vram_data_i = 16'h0000; tile_data_i = 16'h0000;
      err_clr_i = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      reset_n_i = 1'b1;
      tick();

      fetch(1'b0, 16'h1234, 0, 0, -1);          // VRAM, immediate grant
      fetch(1'b1, 16'h0100, 5, 0, -1);          // TILE, grant withheld 5 cycles
      fetch(1'b1, 16'h1400, 0, 0, -1);          // first out-of-range tile address
      fetch(1'b0, 16'h0042, 0, 0, 0);           // err_clr pulse clears the flag
      fetch(1'b1, 16'h13FF, 1, 0, -1);          // last valid tile address
      fetch(1'b0, 16'hBEEF, 100, 0, TO);        // timeout, clear on the set cycle
      fetch(1'b1, 16'hFFFF, 0, 0, 0);           // out-of-range, clear on the set cycle
      fetch(1'b0, 16'h0777, 4, 2, 0);           // withdrawn before grant
      fetch(1'b1, 16'h0ABC, 1, 3, -1);          // withdrawn after grant
      fetch(1'b0, 16'h5555, 2, 2 + 1 + LAT, -1);// withdrawn on the data cycle
      fetch(1'b0, 16'h1111, 0, 0, -1);          // back-to-back pair
      fetch(1'b1, 16'h0222, 0, 0, -1);

      // Reset while waiting for read data.
      audio_req_i = 1'b1; audio_tile_i = 1'b0; audio_addr_i = 16'h2222;
      vram_grant_i = 1'b0; tile_grant_i = 1'b0; err_clr_i = 1'b0;
      tick();
      check_val("rst_pre_vsel", 32'(vram_sel_o), 32'd1);
      vram_grant_i = 1'b1;
      tick();
      vram_grant_i = 1'b0;
      #2 reset_n_i = 1'b0;
      #1 check_all_zero("rst_async");
      audio_req_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_val("rst_no_ack", 32'(audio_ack_o), 32'd0);
         check_val("rst_no_vsel", 32'(vram_sel_o), 32'd0);
      end
      word_m  = 16'h0000;
      err_m   = 1'b0;
      last_ok = 1'b0;
      fetch(1'b0, 16'h3333, 0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         t = 1'($urandom);
         m = $urandom_range(0, 3);
         if (t) a = (m == 0) ? 16'd5119 : (m == 1) ? 16'd5120 : 16'($urandom_range(0, 6000));
         else a = 16'($urandom);
         g  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
         wd = 0;
         m  = $urandom_range(0, 5);
         if (m == 0 && g >= 1) wd = $urandom_range(1, (g < TO - 1) ? g : TO - 1);
         else if (m == 1 && g < TO) wd = g + 1 + $urandom_range(1, LAT);
         clr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
         fetch(t, a, g, wd, clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/audio_mem_fetch.md
Name: audio_mem_fetch

Overview:
- Memory-side server for the audio mixer's sample DMA fetch interface (req/ack, tile select, address, returned word).
- Latches each mixer request and steers it to VRAM or TILE memory.
- Waits for that memory's arbiter grant and fixed read latency, then returns the word with a one-cycle ack.
- Adds a starvation timeout, tile-range protection and a sticky error flag for the audio status register.

Parameters:
- VRAM_W, 16, VRAM word-address width.
- TILE_W, 12, TILE memory word-address width.
- TILE_WORDS, 5120, valid TILE word count; tile addresses >= this are out of range.
- MEM_LAT, 1, cycles from grant cycle to read data valid (1..3).
- TIMEOUT, 255, maximum cycles waiting for grant before forced completion (8-bit counter).

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- audio_req_i  in  1  mixer fetch request (held until ack)
- audio_tile_i  in  1  1=TILE memory, 0=VRAM
- audio_addr_i  in  VRAM_W  sample word address
- audio_ack_o  out  1  one-cycle completion strobe
- audio_word_o  out  16  fetched sample word; valid with ack, held until next ack
- vram_sel_o  out  1  VRAM read request to arbiter
- vram_addr_o  out  VRAM_W  VRAM read address
- vram_grant_i  in  1  arbiter grant (slot taken this cycle)
- vram_data_i  in  16  VRAM read data
- tile_sel_o  out  1  TILE read request to arbiter
- tile_addr_o  out  TILE_W  TILE read address
- tile_grant_i  in  1  TILE arbiter grant
- tile_data_i  in  16  TILE read data
- err_o  out  1  sticky error: timeout or out-of-range tile fetch
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset is asynchronous active-low on reset_n_i; all state is clocked on clk.
- Reset values:
  - State = IDLE.
  - audio_ack_o=0, audio_word_o=0.
  - vram_sel_o=0, tile_sel_o=0, vram_addr_o=0, tile_addr_o=0.
  - err_o=0, counters=0.
- Reset mid-transaction: abandon immediately, with no ack after release.
- States: IDLE, ISSUE, WAIT_DATA, ACK, COOL.
- IDLE:
  - On audio_req_i=1, latch tile flag and address.
  - Tile request with address >= TILE_WORDS: go to ACK with word 0x0000 and set err_o.
  - Otherwise go to ISSUE.
  - Later changes to the address/tile inputs are ignored until the next IDLE.
- ISSUE:
  - Assert vram_sel_o or tile_sel_o with the latched address (tile_addr_o = low TILE_W bits). Never both.
  - Keep the select asserted until grant is seen in the same cycle.
  - On grant: deassert the select next cycle, load the latency counter with MEM_LAT, go to WAIT_DATA.
  - Timeout counter increments each ISSUE cycle. At TIMEOUT without grant: drop the select, go to ACK with word 0x0000, set err_o.
- WAIT_DATA:
  - Decrement the latency counter.
  - Sample selected-memory data on the cycle exactly MEM_LAT cycles after the grant cycle into audio_word_o, then go to ACK.
- ACK:
  - audio_ack_o=1 for exactly one cycle, audio_word_o already valid.
  - Next state COOL.
- COOL:
  - One cycle, ignoring audio_req_i; this absorbs the mixer's registered req drop.
  - Next state IDLE.
- Latency: request seen in IDLE at cycle N with immediate grant → ack at cycle N+2+MEM_LAT. Back-to-back fetches are spaced at least 4+MEM_LAT cycles.
- Request withdrawn (audio_req_i=0) while in ISSUE before grant: drop the select, go to IDLE, no ack.
- Request withdrawn after grant: finish the read, update audio_word_o, suppress ack, go to COOL.
- err_o:
  - Set by timeout or out-of-range tile fetch.
  - err_clr_i clears it; a set event in the same cycle wins.
- A grant on the unselected memory is ignored.
- audio_word_o changes only when entering ACK (or on a suppressed-ack completion).

Test Plan:
- VRAM fetch: MEM_LAT=1, req addr 0x1234 tile=0, grant on first ISSUE cycle, vram_data=0xA55A → vram_addr_o=0x1234, ack one cycle, audio_word_o=0xA55A at N+3, tile_sel_o never asserted.
- TILE fetch, contention: req tile=1 addr 0x0100, tile_grant withheld 5 cycles, then granted, data 0x7F80 → tile_sel_o held 6 cycles, ack 1+MEM_LAT cycles after grant, word 0x7F80, err_o=0.
- Out of range: tile=1 addr 0x1400 (5120) → no tile_sel_o, ack with 0x0000, err_o=1; err_clr_i pulse → err_o=0.
- Timeout: TIMEOUT=8, vram_grant_i held 0 → vram_sel_o high 8 cycles then low, ack with 0x0000, err_o=1; simultaneous err_clr_i on set cycle → err_o stays 1.
- Withdraw/reset: req dropped in ISSUE → no ack, return to IDLE; reset_n_i low while in WAIT_DATA → all outputs 0 asynchronously, no ack after release, next request serviced normally.
- Back-to-back against the mixer handshake (req held until ack, dropped next cycle): two fetches → exactly two acks, COOL prevents duplicate fetch, spacing >= 4+MEM_LAT cycles.
